// File: rtl/uart_host_peer_if.sv
// uart_host_peer_if
//   Groups the three parallel-side handshakes of uart_host_peer.
//   The master modport is the peer itself; the slave modport is the
//   surrounding environment (image ROM, stream source, capture sink).
// Signals
//   img_addr   image ROM word address (peer -> ROM)
//   img_data   ROM word, valid one cycle after img_addr (ROM -> peer)
//   in_valid   stream byte offered (source -> peer)
//   in_data    stream byte
//   in_ready   stream byte accepted when in_valid & in_ready (peer -> source)
//   cap_valid  capture FIFO not empty (peer -> sink)
//   cap_data   capture FIFO head byte
//   cap_ready  pops the head when cap_valid & cap_ready (sink -> peer)
interface uart_host_peer_if #(
    parameter int IMG_AW = 10
);
    logic [IMG_AW-1:0] img_addr;
    logic [31:0]       img_data;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              cap_valid;
    logic [7:0]        cap_data;
    logic              cap_ready;

    modport master (
        output img_addr,
        input  img_data,
        input  in_valid,
        input  in_data,
        output in_ready,
        output cap_valid,
        output cap_data,
        input  cap_ready
    );

    modport slave (
        input  img_addr,
        output img_data,
        output in_valid,
        output in_data,
        input  in_ready,
        input  cap_valid,
        input  cap_data,
        output cap_ready
    );
endinterface

// File: rtl/uart_host_peer.sv
// uart_host_peer
//   Host-side peer of the CPU's UART loader/IO path. Waits for the CPU's
//   sync byte, streams a length-prefixed program image (big-endian), then
//   forwards a byte stream to the CPU. Every byte the CPU emits after sync
//   is captured into a FIFO.
//   Optional feature macro: HOST_PEER_CKSUM_EN appends a 32-bit big-endian
//   trailer holding the sum of all image words (header excluded).
// Ports
//   clk        clock
//   rstn       synchronous, active-low reset
//   rxd        serial in (CPU txd)
//   txd        serial out (CPU rxd)
//   go         start pulse, honoured only in IDLE
//   img_len    image length in words, sampled when go is accepted
//   bus        master modport: image ROM, input stream, capture FIFO
//   cap_ovf    sticky: a captured byte was dropped
//   img_done   level: image (and trailer) fully shifted out
//   state      0 IDLE, 1 WAIT_SYNC, 2 SEND_IMG, 3 STREAM
// Also contains the uart_tx / uart_rx cores (8N1, LSB first).

// uart_tx: one 8N1 frame per start pulse; busy rises the cycle after start.
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC + 1);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;

    // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit; ones shift in
    // behind the data so the stop bit comes out of the register for free.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            txd     <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (!busy) begin
            if (start) begin
                txd     <= 1'b0;
                busy    <= 1'b1;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= {1'b1, data};
            end
        end else if (cnt == CW'(BIT_CYC - 1)) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
                busy <= 1'b0;
            end else begin
                txd     <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// uart_rx: samples mid-bit after a 2-flop synchroniser; ready pulses at the
// middle of the stop bit with ferr set when the stop bit reads 0.
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       ready,
    output logic [7:0] data,
    output logic       ferr
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC + 1);

    logic          r1, r2, active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    // A start bit that is high again at its midpoint is treated as a glitch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r1      <= 1'b1;
            r2      <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ready   <= 1'b0;
            data    <= '0;
            ferr    <= 1'b0;
        end else begin
            r1    <= rxd;
            r2    <= r1;
            ready <= 1'b0;
            if (!active) begin
                if (!r2) begin
                    active  <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            end else if (bit_idx == 4'd0) begin
                if (cnt == CW'(CLK_PER_HALF_BIT - 1)) begin
                    cnt <= '0;
                    if (r2) active  <= 1'b0;
                    else    bit_idx <= 4'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt == CW'(BIT_CYC - 1)) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    ready  <= 1'b1;
                    data   <= shreg;
                    ferr   <= !r2;
                end else begin
                    shreg   <= {r2, shreg[7:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module uart_host_peer #(
    parameter int         CLK_PER_HALF_BIT = 434,
    parameter int         IMG_AW           = 10,
    parameter int         CAP_AW           = 8,
    parameter logic [7:0] SYNC_BYTE        = 8'hAA
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic              txd,
    input  logic              go,
    input  logic [IMG_AW:0]   img_len,
    uart_host_peer_if.master  bus,
    output logic              cap_ovf,
    output logic              img_done,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        SEND_IMG  = 2'd2,
        STREAM    = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic          tx_start, tx_busy, guard, can_start;
    logic [7:0]    tx_data;
    logic          rx_ready, rx_ferr, sync_hit, issue_img;
    logic [7:0]    rx_data;
    logic [IMG_AW:0]   len;
    logic [IMG_AW+1:0] word_idx, last_idx;
    logic [1:0]    byte_sel;
    logic [31:0]   cur_word, next_word;
    logic          sent_all;
`ifdef HOST_PEER_CKSUM_EN
    logic [31:0]   sum;
`endif

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .clk(clk), .rstn(rstn), .start(tx_start), .data(tx_data),
        .txd(txd), .busy(tx_busy)
    );

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk(clk), .rstn(rstn), .rxd(rxd),
        .ready(rx_ready), .data(rx_data), .ferr(rx_ferr)
    );

    // A new byte may only start once the previous start pulse and its guard
    // cycle are over, because busy lags the start pulse.
    assign can_start = !tx_start && !guard && !tx_busy;
    assign sync_hit  = rx_ready && !rx_ferr && (rx_data == SYNC_BYTE);
    assign state     = cur_state;

    // Word 0 is the header, words 1..len the image, word len+1 the trailer.
`ifdef HOST_PEER_CKSUM_EN
    assign last_idx = {1'b0, len} + (IMG_AW+2)'(1);
`else
    assign last_idx = {1'b0, len};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) cur_state <= IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state    = cur_state;
        bus.in_ready = 1'b0;
        issue_img    = 1'b0;
        case (cur_state)
            IDLE:      if (go) nxt_state = WAIT_SYNC;
            WAIT_SYNC: if (sync_hit) nxt_state = SEND_IMG;
            SEND_IMG: begin
                if (can_start) begin
                    if (sent_all) nxt_state = STREAM;
                    else          issue_img = 1'b1;
                end
            end
            STREAM:    bus.in_ready = can_start;
            default:   nxt_state = IDLE;
        endcase
    end

    // Image byte sequencer. The ROM address always points at the next image
    // word, so next_word (ROM output registered every cycle) has settled
    // several byte times before it is loaded into the shift word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_start     <= 1'b0;
            guard        <= 1'b0;
            tx_data      <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_sel     <= '0;
            cur_word     <= '0;
            next_word    <= '0;
            sent_all     <= 1'b0;
            bus.img_addr <= '0;
            img_done     <= 1'b0;
`ifdef HOST_PEER_CKSUM_EN
            sum          <= '0;
`endif
        end else begin
            guard     <= tx_start;
            tx_start  <= 1'b0;
            next_word <= bus.img_data;
            if (cur_state == IDLE && go) begin
                len          <= img_len;
                cur_word     <= 32'(img_len);
                word_idx     <= '0;
                byte_sel     <= '0;
                sent_all     <= 1'b0;
                bus.img_addr <= '0;
`ifdef HOST_PEER_CKSUM_EN
                sum          <= '0;
`endif
            end
            if (issue_img) begin
                tx_start <= 1'b1;
                tx_data  <= cur_word[31:24];
                byte_sel <= byte_sel + 2'd1;
                if (byte_sel != 2'd3) begin
                    cur_word <= {cur_word[23:0], 8'h00};
                end else if (word_idx == last_idx) begin
                    sent_all <= 1'b1;
                end else begin
                    word_idx <= word_idx + (IMG_AW+2)'(1);
                    if (word_idx < {1'b0, len}) begin
                        cur_word     <= next_word;
                        bus.img_addr <= bus.img_addr + IMG_AW'(1);
`ifdef HOST_PEER_CKSUM_EN
                        sum          <= sum + next_word;
`endif
                    end
`ifdef HOST_PEER_CKSUM_EN
                    else begin
                        cur_word <= sum;
                    end
`endif
                end
            end
            if (cur_state == SEND_IMG && nxt_state == STREAM) img_done <= 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                tx_start <= 1'b1;
                tx_data  <= bus.in_data;
            end
        end
    end

    // Capture FIFO: extra pointer MSB distinguishes full from empty; the
    // output is registered storage only, so a push into an empty FIFO shows
    // up one cycle later.
    logic [7:0]    mem [2**CAP_AW];
    logic [CAP_AW:0] wptr, rptr;
    logic          full, empty, push_req, push_ok, pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[CAP_AW] != rptr[CAP_AW]) &&
                      (wptr[CAP_AW-1:0] == rptr[CAP_AW-1:0]);
    assign push_req = (cur_state == SEND_IMG || cur_state == STREAM) &&
                      rx_ready && !rx_ferr;
    assign pop      = !empty && bus.cap_ready;
    assign push_ok  = push_req && (!full || pop);

    assign bus.cap_valid = !empty;
    assign bus.cap_data  = mem[rptr[CAP_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[CAP_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            cap_ovf <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + (CAP_AW+1)'(1);
            if (pop)     rptr <= rptr + (CAP_AW+1)'(1);
            if (push_req && full && !pop) cap_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_host_peer.sv
// tb_uart_host_peer
//   Directed bench for uart_host_peer. Expected txd bytes and capture bytes
//   are queued as stimulus is issued; independent monitor processes decode
//   txd and watch the capture handshake, popping and comparing.
//   Build with HOST_PEER_CKSUM_EN defined to expect checksum trailers.
module tb_uart_host_peer;
    localparam int H      = 8;
    localparam int IMG_AW = 10;
    localparam int CAP_AW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              rxd;
    logic              txd;
    logic              go;
    logic [IMG_AW:0]   img_len;
    logic              cap_ovf;
    logic              img_done;
    logic [1:0]        state;

    uart_host_peer_if #(.IMG_AW(IMG_AW)) bus ();

    uart_host_peer #(
        .CLK_PER_HALF_BIT(H), .IMG_AW(IMG_AW), .CAP_AW(CAP_AW), .SYNC_BYTE(8'hAA)
    ) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .go(go),
        .img_len(img_len), .bus(bus.master), .cap_ovf(cap_ovf),
        .img_done(img_done), .state(state)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM.
    logic [31:0] rom [0:(2**IMG_AW)-1];
    always @(posedge clk) bus.img_data <= rom[bus.img_addr];

    logic [7:0] txq[$];
    logic [7:0] capq[$];
    int vectors = 0;
    int miscompares = 0;
    int tx_seen = 0;
    bit mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // txd decoder: samples on falling clock edges at bit midpoints.
    initial begin : txMon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (H) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (2*H) @(negedge clk);
                    b[i] = txd;
                end
                repeat (2*H) @(negedge clk);
                if (mon_en) begin
                    tx_seen++;
                    if (txq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL txd_extra: got %h, expected no byte", b);
                    end else begin
                        checkOutput("txd_byte", 32'(b), 32'(txq.pop_front()));
                    end
                end
            end
        end
    end

    // Capture sink monitor.
    initial begin : capMon
        forever begin
            @(negedge clk);
            if (bus.cap_valid === 1'b1 && bus.cap_ready === 1'b1) begin
                if (capq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL cap_extra: got %h, expected no byte", bus.cap_data);
                end else begin
                    checkOutput("cap_data", 32'(bus.cap_data), 32'(capq.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [IMG_AW:0] len);
        img_len = len;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic cpuSend(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (2*H) @(posedge clk); #1;
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        txq.push_back(w[31:24]);
        txq.push_back(w[23:16]);
        txq.push_back(w[15:8]);
        txq.push_back(w[7:0]);
    endtask

    task automatic waitState(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(state), 32'(s));
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while ((txq.size() != 0 || capq.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(txq.size() + capq.size()), 32'd0);
    endtask

    task automatic pulseReset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // Offers a stream byte and waits (bounded) until it is accepted.
    task automatic streamByte(input logic [7:0] b, input string name);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : main
        int seen0;
        rstn = 1'b0;
        rxd = 1'b1;
        go = 1'b0;
        img_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.cap_ready = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset values
        checkOutput("rst_txd", 32'(txd), 32'd1);
        checkOutput("rst_img_addr", 32'(bus.img_addr), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_cap_valid", 32'(bus.cap_valid), 32'd0);
        checkOutput("rst_cap_ovf", 32'(cap_ovf), 32'd0);
        checkOutput("rst_img_done", 32'(img_done), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        rstn = 1'b1;

        // T1: reset in the middle of the header byte
        rom[0] = 32'h12345678;
        rom[1] = 32'hDEADBEEF;
        applyStimulus(11'd2);
        checkOutput("t1_wait_sync", 32'(state), 32'd1);
        cpuSend(8'hAA);
        waitState(2'd2, 400, "t1_send_img");
        repeat (3*H) @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        checkOutput("t1_txd", 32'(txd), 32'd1);
        checkOutput("t1_state", 32'(state), 32'd0);
        checkOutput("t1_cap_valid", 32'(bus.cap_valid), 32'd0);
        checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("t1_cap_ovf", 32'(cap_ovf), 32'd0);
        rstn = 1'b1;
        repeat (30*H) @(posedge clk); #1;
        mon_en = 1'b1;

        // T2: non-sync byte ignored, then full image
        seen0 = tx_seen;
        applyStimulus(11'd2);
        cpuSend(8'h55);
        repeat (4*H) @(posedge clk); #1;
        checkOutput("t2_still_wait", 32'(state), 32'd1);
        checkOutput("t2_nothing_sent", 32'(tx_seen), 32'(seen0));
        pushWord(32'h00000002);
        pushWord(32'h12345678);
        pushWord(32'hDEADBEEF);
`ifdef HOST_PEER_CKSUM_EN
        pushWord(32'hF0E21567);
`endif
        cpuSend(8'hAA);
        waitState(2'd3, 6000, "t2_stream");
        checkOutput("t2_img_done", 32'(img_done), 32'd1);
        waitDrain(800, "t2_drain");

        // T4: two stream bytes back to back
        txq.push_back(8'h41);
        txq.push_back(8'h42);
        streamByte(8'h41, "t4_accept_41");
        bus.in_data = 8'h42;
        checkOutput("t4_ready_pending", 32'(bus.in_ready), 32'd0);
        repeat (6*H) @(posedge clk); #1;
        checkOutput("t4_ready_busy", 32'(bus.in_ready), 32'd0);
        streamByte(8'h42, "t4_accept_42");
        bus.in_valid = 1'b0;
        waitDrain(800, "t4_drain");
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        checkOutput("t4_go_ignored", 32'(state), 32'd3);

        // T5: capture FIFO overflow (depth 4)
        for (int i = 1; i <= 4; i++) begin
            capq.push_back(8'(i));
            cpuSend(8'(i));
        end
        repeat (4) @(posedge clk); #1;
        checkOutput("t5_ovf_at_full", 32'(cap_ovf), 32'd0);
        checkOutput("t5_cap_valid", 32'(bus.cap_valid), 32'd1);
        cpuSend(8'h05);
        repeat (4) @(posedge clk); #1;
        checkOutput("t5_ovf_set", 32'(cap_ovf), 32'd1);
        bus.cap_ready = 1'b1;
        waitDrain(100, "t5_drain");
        @(posedge clk); #1;
        checkOutput("t5_empty", 32'(bus.cap_valid), 32'd0);
        bus.cap_ready = 1'b0;

        // T3: zero-length image
        pulseReset();
        applyStimulus(11'd0);
        pushWord(32'h00000000);
`ifdef HOST_PEER_CKSUM_EN
        pushWord(32'h00000000);
`endif
        cpuSend(8'hAA);
        waitState(2'd3, 3000, "t3_stream");
        checkOutput("t3_img_done", 32'(img_done), 32'd1);
        waitDrain(800, "t3_drain");

        // T6: checksum wraps to zero
        pulseReset();
        rom[0] = 32'h00000001;
        rom[1] = 32'hFFFFFFFF;
        applyStimulus(11'd2);
        pushWord(32'h00000002);
        pushWord(32'h00000001);
        pushWord(32'hFFFFFFFF);
`ifdef HOST_PEER_CKSUM_EN
        pushWord(32'h00000000);
`endif
        cpuSend(8'hAA);
        waitState(2'd2, 400, "t6_send_img");
        checkOutput("t6_not_done", 32'(img_done), 32'd0);
        waitState(2'd3, 6000, "t6_stream");
        checkOutput("t6_img_done", 32'(img_done), 32'd1);
        waitDrain(800, "t6_drain");

        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
